// File: rtl/hamming_tx_serializer_if.sv
// Codeword handshake between the Hamming (7,4) encoder and the line serializer.
// The master drives a codeword and valid; the slave returns ready when its holding register is empty.
interface hamming_tx_serializer_if;
    logic [6:0] cw_in;
    logic       cw_valid;
    logic       cw_ready;

    modport master (output cw_in, output cw_valid, input cw_ready);
    modport slave  (input cw_in, input cw_valid, output cw_ready);
endinterface

// File: rtl/hamming_tx_serializer.sv
// Buffers one 7-bit Hamming codeword and shifts it out as start bit, 7 bits LSB first, stop bit.
// The line idles high, and the next frame follows the stop bit directly when a codeword is already waiting.
module hamming_tx_serializer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    hamming_tx_serializer_if.slave   cw,
    output logic                     tx_out,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_reg, state_next;
    logic [6:0]    hold_reg;
    logic          hold_valid_reg;
    logic [6:0]    shift_reg, shift_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [2:0]    index_reg, index_next;
    logic          tx_reg, tx_next;
    logic          busy_reg;
    logic          frame_done_reg, frame_done_next;
    logic          take;
    logic          bit_end;
    logic          load;

    assign cw.cw_ready = ~hold_valid_reg;
    assign load        = cw.cw_valid & ~hold_valid_reg;
    assign tx_out      = tx_reg;
    assign busy        = busy_reg;
    assign frame_done  = frame_done_reg;

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        index_next = index_reg;
        shift_next = shift_reg;
        take       = 1'b0;
        bit_end    = (timer_reg == LAST);

        if (state_reg != IDLE)
            timer_next = bit_end ? '0 : timer_reg + 1'b1;

        case (state_reg)
            IDLE: begin
                if (hold_valid_reg) begin
                    take       = 1'b1;
                    state_next = START;
                    timer_next = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    index_next = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (index_reg == 3'd6)
                        state_next = STOP;
                    else
                        index_next = index_reg + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // A waiting codeword starts immediately so frames run back to back.
                    if (hold_valid_reg) begin
                        take       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (take)
            shift_next = hold_reg;

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[index_next];
            default: tx_next = 1'b1;
        endcase

        // Predicting the final stop cycle one edge early keeps the pulse registered.
        frame_done_next = (state_next == STOP) && (timer_next == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hold_reg       <= '0;
            hold_valid_reg <= 1'b0;
            shift_reg      <= '0;
            timer_reg      <= '0;
            index_reg      <= '0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            timer_reg      <= timer_next;
            index_reg      <= index_next;
            tx_reg         <= tx_next;
            busy_reg       <= (state_next != IDLE);
            frame_done_reg <= frame_done_next;
            if (load) begin
                hold_reg       <= cw.cw_in;
                hold_valid_reg <= 1'b1;
            end else if (take) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Directed bench for hamming_tx_serializer at four and one clocks per line bit.
module tb_hamming_tx_serializer;
    logic clk;
    logic rst_n;
    logic tx4, busy4, fd4;
    logic tx1, busy1, fd1;
    int   n_cmp;
    int   n_fail;

    hamming_tx_serializer_if if4 ();
    hamming_tx_serializer_if if1 ();

    hamming_tx_serializer #(.CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .cw(if4.slave),
        .tx_out(tx4), .busy(busy4), .frame_done(fd4)
    );

    hamming_tx_serializer #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .cw(if1.slave),
        .tx_out(tx1), .busy(busy1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] cw;
        logic [8:0] line;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Waits (bounded) for ready, then performs one transfer; returns just after the transfer edge.
    task automatic transfer4(input logic [6:0] value);
        @(posedge clk);
        #1;
        for (int k = 0; k < 200 && !if4.cw_ready; k++) begin
            @(posedge clk);
            #1;
        end
        check("xfer_ready", if4.cw_ready, 1);
        if4.cw_in    = value;
        if4.cw_valid = 1'b1;
        @(posedge clk);
        #1;
        if4.cw_valid = 1'b0;
        $display("xfer cw=%02h", value);
    endtask

    task automatic frame4(input logic [8:0] line);
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("lat_tx", tx4, 1);
                check("lat_busy", busy4, 0);
                check("lat_ready", if4.cw_ready, 0);
            end else if (i <= 36) begin
                check("frame_tx", tx4, line[(i - 1) / 4]);
                check("frame_busy", busy4, 1);
                check("frame_done", fd4, (i == 36) ? 1 : 0);
            end else begin
                check("post_tx", tx4, 1);
                check("post_busy", busy4, 0);
                check("post_ready", if4.cw_ready, 1);
                check("post_fd", fd4, 0);
            end
        end
        $display("frame line=%03h done", line);
    endtask

    // mode 0: one extra codeword mid-frame; mode 1: valid held with cw_in changing every cycle.
    task automatic two_frames(input logic [8:0] line_a, input logic [8:0] line_b,
                              input int mode, input int rdy_lo);
        logic [8:0] ln;
        int         k;
        for (int i = 0; i < 74; i++) begin
            @(negedge clk);
            if (i == 0 || i == 73) begin
                check("pair_idle_tx", tx4, 1);
                check("pair_idle_busy", busy4, 0);
            end else begin
                ln = (i <= 36) ? line_a : line_b;
                k  = ((i - 1) % 36) / 4;
                check("pair_tx", tx4, ln[k]);
                check("pair_busy", busy4, 1);
                check("pair_fd", fd4, (i == 36 || i == 72) ? 1 : 0);
            end
            check("pair_ready", if4.cw_ready,
                  (i == 0 || (i >= rdy_lo && i <= 36)) ? 0 : 1);
            if (mode == 0) begin
                if (i == 12) begin
                    if4.cw_in    = 7'h2A;
                    if4.cw_valid = 1'b1;
                end else begin
                    if4.cw_valid = 1'b0;
                end
            end else begin
                if4.cw_in    = 7'(i * 13 + 5);
                if4.cw_valid = (i < 37);
            end
        end
        $display("pair lines=%03h,%03h mode=%0d done", line_a, line_b, mode);
    endtask

    initial begin
        logic [8:0] line1;
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{cw: 7'h55, line: 9'h1AA};
        vecs[1] = '{cw: 7'h2A, line: 9'h154};
        vecs[2] = '{cw: 7'h7F, line: 9'h1FE};
        vecs[3] = '{cw: 7'h00, line: 9'h100};
        vecs[4] = '{cw: 7'h01, line: 9'h102};
        vecs[5] = '{cw: 7'h40, line: 9'h180};

        rst_n = 1'b0;
        if4.cw_in = '0; if4.cw_valid = 1'b0;
        if1.cw_in = '0; if1.cw_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx4", tx4, 1);
        check("rst_busy4", busy4, 0);
        check("rst_fd4", fd4, 0);
        check("rst_ready4", if4.cw_ready, 1);
        check("rst_tx1", tx1, 1);
        check("rst_ready1", if1.cw_ready, 1);
        $display("reset values checked");
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            transfer4(vecs[v].cw);
            frame4(vecs[v].line);
        end

        transfer4(7'h55);
        two_frames(9'h1AA, 9'h154, 0, 13);

        // The value present on the first ready edge (i=1 -> 7'h12) is the one sent.
        transfer4(7'h00);
        two_frames(9'h100, 9'h124, 1, 2);

        transfer4(7'h00);
        for (int i = 0; i <= 18; i++) begin
            @(negedge clk);
            if (i == 5) begin
                if4.cw_in    = 7'h2A;
                if4.cw_valid = 1'b1;
            end else begin
                if4.cw_valid = 1'b0;
            end
        end
        check("pre_rst_tx", tx4, 0);
        check("pre_rst_busy", busy4, 1);
        check("pre_rst_ready", if4.cw_ready, 0);
        #1 rst_n = 1'b0;
        #1;
        check("async_tx", tx4, 1);
        check("async_busy", busy4, 0);
        check("async_ready", if4.cw_ready, 1);
        check("async_fd", fd4, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("inrst_tx", tx4, 1);
            check("inrst_fd", fd4, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("discard_busy", busy4, 0);
            check("discard_tx", tx4, 1);
        end
        $display("mid-frame reset checked");
        transfer4(7'h7F);
        frame4(9'h1FE);

        @(posedge clk);
        #1;
        if1.cw_in    = 7'h01;
        if1.cw_valid = 1'b1;
        @(posedge clk);
        #1;
        if1.cw_valid = 1'b0;
        line1 = 9'h102;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            if (i == 0 || i == 10) begin
                check("cpb1_idle_tx", tx1, 1);
                check("cpb1_idle_busy", busy1, 0);
            end else begin
                check("cpb1_tx", tx1, line1[i - 1]);
                check("cpb1_fd", fd1, (i == 9) ? 1 : 0);
            end
        end
        $display("cpb1 frame cw=01 done");

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_tx", tx4, 1);
            check("idle_busy", busy4, 0);
            check("idle_fd", fd4, 0);
        end
        $display("idle 100 cycles done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
